// File: rtl/fnd_scan_driver_pkg.sv
// Shared types and constants for the 4-digit FND scan driver.
// Covers the controller FSM states, the digit/width constants and the double-dabble nibble correction.
package fnd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        UPDATE = 2'd2
    } fsm_state_t;

    localparam int               FND_DIGITS   = 4;
    localparam int               BIN_W        = 14;
    localparam int               BCD_W        = 4 * FND_DIGITS;
    localparam logic [BIN_W-1:0] BCD_MAX      = 14'd9999;
    localparam logic [3:0]       FND_DOT_CODE = 4'ha;

    // Double-dabble correction applied to a BCD nibble before each shift.
    function automatic logic [3:0] dabble_adj(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

endpackage

// File: rtl/fnd_scan_driver_if.sv
// Load/capture and scan-output bundle of the FND scan driver.
// The slave modport belongs to the driver; the master modport belongs to whoever feeds it and watches the display.
interface fnd_scan_driver_if;
    import fnd_pkg::*;

    logic             i_Load;
    logic [BIN_W-1:0] i_Bin;
    logic             i_LZB;
    logic             o_Busy;
    logic             o_Overflow;
    logic [3:0]       o_Digit_Sel;
    logic [3:0]       o_Value;
    logic             o_Blank;

    modport slave (
        input  i_Load, i_Bin, i_LZB,
        output o_Busy, o_Overflow, o_Digit_Sel, o_Value, o_Blank
    );

    modport master (
        output i_Load, i_Bin, i_LZB,
        input  o_Busy, o_Overflow, o_Digit_Sel, o_Value, o_Blank
    );

endinterface

// File: rtl/fnd_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: one adjust-and-shift step per clock.
// A full conversion takes BIN_W clocks after the load edge.
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [BIN_W-1:0] i_bin,
    output logic             o_busy,
    output logic             o_done,
    output logic [BCD_W-1:0] o_bcd
);

    localparam logic [3:0] LAST_SHIFT = 4'(BIN_W - 1);

    logic [BIN_W-1:0] r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [3:0]       r_cnt;
    logic             r_run;
    logic [BCD_W-1:0] w_adj;

    for (genvar gi = 0; gi < FND_DIGITS; gi++) begin : g_adj
        assign w_adj[gi*4 +: 4] = dabble_adj(r_bcd[gi*4 +: 4]);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_load && !r_run) begin
            r_bin <= i_bin;
            r_bcd <= '0;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
            r_cnt          <= r_cnt + 4'd1;
            if (r_cnt == LAST_SHIFT) begin
                r_run <= 1'b0;
            end
        end
    end

    // Done flags the edge that performs the final shift, so the result is stable one clock later.
    assign o_busy = r_run;
    assign o_done = r_run && (r_cnt == LAST_SHIFT);
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/fnd_scan_driver.sv
// Captures a binary count, converts it to BCD, and scans four digits onto one decoder input.
// Also handles leading-zero blanking and the overflow (dot-only) display.
module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int DIGIT_HZ = 1_000,
    parameter int SCAN_DIV = CLK_HZ / DIGIT_HZ
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    fnd_scan_driver_if.slave   bus
);

    localparam int             PRE_W    = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    fsm_state_t        r_state;
    logic              r_busy;
    logic              r_ovf;
    logic              r_cap_ovf;
    logic [3:0]        r_disp [FND_DIGITS];
    logic [PRE_W-1:0]  r_pre;
    logic [1:0]        r_idx;
    logic [3:0]        r_sel;
    logic [3:0]        r_value;
    logic              r_blank;

    logic              w_load;
    logic              w_conv_busy;
    logic              w_conv_done;
    logic [BCD_W-1:0]  w_bcd;
    logic [FND_DIGITS-1:0] w_lzb_blank;
    logic              w_run_zero;

    assign w_load = bus.i_Load && (r_state == IDLE) && !w_conv_busy;

    bin2bcd_seq u_bin2bcd (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (w_load),
        .i_bin     (bus.i_Bin),
        .o_busy    (w_conv_busy),
        .o_done    (w_conv_done),
        .o_bcd     (w_bcd)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_ovf     <= 1'b0;
            r_cap_ovf <= 1'b0;
            for (int i = 0; i < FND_DIGITS; i++) r_disp[i] <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_cap_ovf <= (bus.i_Bin > BCD_MAX);
                        r_busy    <= 1'b1;
                        r_state   <= CONV;
                    end
                end
                CONV: begin
                    if (w_conv_done) r_state <= UPDATE;
                end
                UPDATE: begin
                    // An out-of-range capture keeps the old digits; the dot display hides them anyway.
                    if (!r_cap_ovf) begin
                        for (int i = 0; i < FND_DIGITS; i++) r_disp[i] <= w_bcd[i*4 +: 4];
                    end
                    r_ovf   <= r_cap_ovf;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Digit k blanks when it and every more significant digit are zero; the ones digit never blanks.
    always_comb begin
        w_lzb_blank = '0;
        w_run_zero  = 1'b1;
        for (int k = FND_DIGITS - 1; k >= 1; k--) begin
            w_run_zero     = w_run_zero && (r_disp[k] == 4'd0);
            w_lzb_blank[k] = w_run_zero;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pre   <= '0;
            r_idx   <= 2'd0;
            r_sel   <= 4'b1110;
            r_value <= 4'd0;
            r_blank <= 1'b0;
        end else begin
            if (r_pre == PRE_LAST) begin
                r_pre <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end
            r_sel <= ~(4'b0001 << r_idx);
            if (r_ovf) begin
                r_value <= FND_DOT_CODE;
                r_blank <= 1'b0;
            end else begin
                r_value <= r_disp[r_idx];
                r_blank <= bus.i_LZB && w_lzb_blank[r_idx];
            end
        end
    end

    assign bus.o_Busy      = r_busy;
    assign bus.o_Overflow  = r_ovf;
    assign bus.o_Digit_Sel = r_sel;
    assign bus.o_Value     = r_value;
    assign bus.o_Blank     = r_blank;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Randomised self-checking bench for fnd_scan_driver with SCAN_DIV = 4.
// Expected digits come from decimal arithmetic on the last accepted value.
module tb_fnd_scan_driver;
    import fnd_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fnd_scan_driver_if bus();

    fnd_scan_driver #(
        .CLK_HZ   (100_000_000),
        .DIGIT_HZ (1_000),
        .SCAN_DIV (4)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference display state: last accepted in-range value and the overflow flag.
    int m_val = 0;
    bit m_ovf = 1'b0;

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic int sel_to_k(input logic [3:0] s);
        case (s)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [3:0] exp_val(input int k);
        if (m_ovf) return 4'ha;
        if (k < 0) return 4'd0;
        return 4'((m_val / pow10(k)) % 10);
    endfunction

    function automatic logic exp_blank(input int k, input logic lzb);
        if (m_ovf || k <= 0) return 1'b0;
        return lzb && (m_val < pow10(k));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v);
        bus.i_Bin  = 14'(v);
        bus.i_Load = 1'b1;
        tick();
        bus.i_Load = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] esel;
        bus.i_Load = 1'b0;
        bus.i_Bin  = '0;
        bus.i_LZB  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (bus.o_Busy !== 1'b0 || bus.o_Overflow !== 1'b0 || bus.o_Digit_Sel !== 4'b1110 ||
            bus.o_Value !== 4'd0 || bus.o_Blank !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b ovf=%b sel=%b val=%h blank=%b, required 0 0 1110 0 0",
                     bus.o_Busy, bus.o_Overflow, bus.o_Digit_Sel, bus.o_Value, bus.o_Blank);
        end
        rst_n = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            esel = ~(4'b0001 << (((t - 1) / 4) % 4));
            n_vec++;
            if (bus.o_Digit_Sel !== esel || bus.o_Value !== 4'd0 || bus.o_Blank !== 1'b0) begin
                n_err++;
                $display("FAIL scan_cadence t=%0d: sel=%b val=%h blank=%b, required sel=%b val=0 blank=0",
                         t, bus.o_Digit_Sel, bus.o_Value, bus.o_Blank, esel);
            end
        end
    endtask

    task automatic test_load_1234();
        int k;
        bus.i_LZB = 1'b0;
        do_load(1234);
        for (int i = 0; i < 15; i++) begin
            n_vec++;
            if (bus.o_Busy !== 1'b1) begin
                n_err++;
                $display("FAIL busy_high N+%0d: busy=%b, required 1", i, bus.o_Busy);
            end
            if (i < 14) tick();
        end
        tick();
        n_vec++;
        if (bus.o_Busy !== 1'b0 || bus.o_Overflow !== 1'b0) begin
            n_err++;
            $display("FAIL busy_drop N+15: busy=%b ovf=%b, required 0 0", bus.o_Busy, bus.o_Overflow);
        end
        m_val = 1234;
        m_ovf = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick();
            k = sel_to_k(bus.o_Digit_Sel);
            n_vec++;
            if (k < 0 || bus.o_Value !== exp_val(k) || bus.o_Blank !== exp_blank(k, bus.i_LZB)) begin
                n_err++;
                $display("FAIL disp_1234: sel=%b val=%h blank=%b, required val=%h blank=%b",
                         bus.o_Digit_Sel, bus.o_Value, bus.o_Blank, exp_val(k), exp_blank(k, bus.i_LZB));
            end
        end
    endtask

    task automatic test_lzb();
        int k;
        int cyc;
        bus.i_LZB = 1'b1;
        do_load(7);
        cyc = 1;
        while (bus.o_Busy && cyc < 30) begin tick(); cyc++; end
        n_vec++;
        if (cyc !== 16) begin
            n_err++;
            $display("FAIL lzb_busy_len: busy samples=%0d, required 15", cyc - 1);
        end
        m_val = 7;
        m_ovf = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                bus.i_LZB = 1'b0;
                tick();
            end
            for (int c = 0; c < 16; c++) begin
                tick();
                k = sel_to_k(bus.o_Digit_Sel);
                n_vec++;
                if (k < 0 || bus.o_Value !== exp_val(k) || bus.o_Blank !== exp_blank(k, bus.i_LZB)) begin
                    n_err++;
                    $display("FAIL lzb_7 lzb=%b: sel=%b val=%h blank=%b, required val=%h blank=%b",
                             bus.i_LZB, bus.o_Digit_Sel, bus.o_Value, bus.o_Blank,
                             exp_val(k), exp_blank(k, bus.i_LZB));
                end
            end
        end
    endtask

    task automatic test_overflow();
        int k;
        int cyc;
        int vals [2] = '{10000, 9999};
        bus.i_LZB = 1'b1;
        for (int j = 0; j < 2; j++) begin
            do_load(vals[j]);
            cyc = 1;
            while (bus.o_Busy && cyc < 30) begin tick(); cyc++; end
            m_ovf = (vals[j] > 9999);
            if (!m_ovf) m_val = vals[j];
            n_vec++;
            if (cyc !== 16 || bus.o_Overflow !== m_ovf) begin
                n_err++;
                $display("FAIL ovf_flag %0d: busy samples=%0d ovf=%b, required 15 %b",
                         vals[j], cyc - 1, bus.o_Overflow, m_ovf);
            end
            for (int c = 0; c < 16; c++) begin
                tick();
                k = sel_to_k(bus.o_Digit_Sel);
                n_vec++;
                if (k < 0 || bus.o_Value !== exp_val(k) || bus.o_Blank !== exp_blank(k, bus.i_LZB)) begin
                    n_err++;
                    $display("FAIL ovf_disp %0d: sel=%b val=%h blank=%b, required val=%h blank=%b",
                             vals[j], bus.o_Digit_Sel, bus.o_Value, bus.o_Blank,
                             exp_val(k), exp_blank(k, bus.i_LZB));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        int cyc;
        bus.i_LZB = 1'b0;
        do_load(1234);
        repeat (4) tick();
        bus.i_Bin  = 14'd5678;
        bus.i_Load = 1'b1;
        tick();
        bus.i_Load = 1'b0;
        repeat (9) tick();
        n_vec++;
        if (bus.o_Busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_busy N+14: busy=%b, required 1", bus.o_Busy);
        end
        bus.i_Bin  = 14'd1111;
        bus.i_Load = 1'b1;
        tick();
        n_vec++;
        if (bus.o_Busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_update_load N+15: busy=%b, required 0", bus.o_Busy);
        end
        bus.i_Bin = 14'd5678;
        tick();
        bus.i_Load = 1'b0;
        n_vec++;
        if (bus.o_Busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_reload N+16: busy=%b, required 1", bus.o_Busy);
        end
        m_val = 1234;
        m_ovf = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            k = sel_to_k(bus.o_Digit_Sel);
            n_vec++;
            if (k < 0 || bus.o_Value !== exp_val(k) || bus.o_Blank !== exp_blank(k, bus.i_LZB)) begin
                n_err++;
                $display("FAIL b2b_hold: sel=%b val=%h blank=%b, required val=%h blank=%b",
                         bus.o_Digit_Sel, bus.o_Value, bus.o_Blank, exp_val(k), exp_blank(k, bus.i_LZB));
            end
        end
        cyc = 0;
        while (bus.o_Busy && cyc < 30) begin tick(); cyc++; end
        n_vec++;
        if (bus.o_Busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_timeout: busy=%b after %0d cycles, required 0", bus.o_Busy, cyc);
        end
        m_val = 5678;
        for (int c = 0; c < 16; c++) begin
            tick();
            k = sel_to_k(bus.o_Digit_Sel);
            n_vec++;
            if (k < 0 || bus.o_Value !== exp_val(k) || bus.o_Blank !== exp_blank(k, bus.i_LZB)) begin
                n_err++;
                $display("FAIL b2b_5678: sel=%b val=%h blank=%b, required val=%h blank=%b",
                         bus.o_Digit_Sel, bus.o_Value, bus.o_Blank, exp_val(k), exp_blank(k, bus.i_LZB));
            end
        end
    endtask

    task automatic test_reset_midconv();
        int k;
        bus.i_LZB = 1'b0;
        do_load(4321);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.o_Busy !== 1'b0 || bus.o_Overflow !== 1'b0 || bus.o_Digit_Sel !== 4'b1110 ||
            bus.o_Value !== 4'd0 || bus.o_Blank !== 1'b0) begin
            n_err++;
            $display("FAIL midconv_reset: busy=%b ovf=%b sel=%b val=%h blank=%b, required 0 0 1110 0 0",
                     bus.o_Busy, bus.o_Overflow, bus.o_Digit_Sel, bus.o_Value, bus.o_Blank);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_val = 0;
        m_ovf = 1'b0;
        for (int c = 0; c < 24; c++) begin
            tick();
            k = sel_to_k(bus.o_Digit_Sel);
            n_vec++;
            if (k < 0 || bus.o_Busy !== 1'b0 || bus.o_Value !== exp_val(k) ||
                bus.o_Blank !== exp_blank(k, bus.i_LZB)) begin
                n_err++;
                $display("FAIL midconv_after: busy=%b sel=%b val=%h blank=%b, required busy=0 val=%h blank=%b",
                         bus.o_Busy, bus.o_Digit_Sel, bus.o_Value, bus.o_Blank,
                         exp_val(k), exp_blank(k, bus.i_LZB));
            end
        end
    endtask

    task automatic test_random();
        int k;
        int cyc;
        int v;
        for (int it = 0; it < 16; it++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 99);
                1:       v = $urandom_range(10000, 16383);
                default: v = $urandom_range(0, 9999);
            endcase
            bus.i_LZB = 1'($urandom_range(0, 1));
            do_load(v);
            cyc = 1;
            while (bus.o_Busy && cyc < 30) begin tick(); cyc++; end
            m_ovf = (v > 9999);
            if (!m_ovf) m_val = v;
            n_vec++;
            if (cyc !== 16 || bus.o_Overflow !== m_ovf) begin
                n_err++;
                $display("FAIL rnd_flags v=%0d: busy samples=%0d ovf=%b, required 15 %b",
                         v, cyc - 1, bus.o_Overflow, m_ovf);
            end
            for (int c = 0; c < 16; c++) begin
                tick();
                k = sel_to_k(bus.o_Digit_Sel);
                n_vec++;
                if (k < 0 || bus.o_Value !== exp_val(k) || bus.o_Blank !== exp_blank(k, bus.i_LZB)) begin
                    n_err++;
                    $display("FAIL rnd_disp v=%0d lzb=%b: sel=%b val=%h blank=%b, required val=%h blank=%b",
                             v, bus.i_LZB, bus.o_Digit_Sel, bus.o_Value, bus.o_Blank,
                             exp_val(k), exp_blank(k, bus.i_LZB));
                end
            end
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load_1234();
        test_lzb();
        test_overflow();
        test_back_to_back();
        test_reset_midconv();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
